segment_access_ctrl: RTL

Arbiter and sequencer for the 8086-style segment register file (CS/DS/SS/ES). It shares the file's single port between three requesters: segment-load writes from the execution unit, instruction-fetch address generation (always CS), and operand address generation (default segment plus optional override). For reads it forms the 20-bit physical address `{segment, 4'b0} + offset`.

---
 rtl/segment_access_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/segment_access_ctrl.sv
// segment_access_ctrl: arbitrates the segment register file port between segment loads, instruction fetch and operand address generation (optional SEG_OVERRIDE_EN enables override-prefix segment selection)
module segment_access_ctrl #(
  parameter int SEG_W = 16,
  parameter int SHIFT = 4,
  localparam int ADDR_W = SEG_W + SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [1:0]        wr_sel,
  input  logic [SEG_W-1:0]  wr_data,
  output logic              wr_ack,
  input  logic              if_req,
  input  logic [SEG_W-1:0]  if_offset,
  output logic              if_ack,
  output logic [ADDR_W-1:0] if_addr,
  input  logic              eu_req,
  input  logic [1:0]        eu_seg,
  input  logic [SEG_W-1:0]  eu_offset,
  input  logic              eu_ovr_valid,
  input  logic [1:0]        eu_ovr_seg,
  output logic              eu_ack,
  output logic [ADDR_W-1:0] eu_addr,
  output logic              seg_we,
  output logic [1:0]        seg_sel,
  output logic [SEG_W-1:0]  seg_data,
  input  logic [SEG_W-1:0]  seg_q,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WR, RD, AD} state_t;
  state_t state;
  logic rr;
  logic who_eu;
  logic [SEG_W-1:0] off;
  logic [1:0] eu_sel;
  logic wr_v, if_v, eu_v, pick_eu;
  logic [ADDR_W-1:0] sum;
`ifdef SEG_OVERRIDE_EN
  assign eu_sel = eu_ovr_valid ? eu_ovr_seg : eu_seg;
`else
  logic unused_ovr;
  assign unused_ovr = ^{eu_ovr_valid, eu_ovr_seg};
  assign eu_sel = eu_seg;
`endif
  // Requests whose ack is still high are masked so a dropping requester is not granted twice
  always_comb begin
    wr_v = wr_req && !wr_ack;
    if_v = if_req && !if_ack;
    eu_v = eu_req && !eu_ack;
    pick_eu = eu_v && (rr || !if_v);
    sum = {seg_q, {SHIFT{1'b0}}} + ADDR_W'(off);
  end
  // Sequencer: IDLE grants, WR drives the write for one cycle, RD selects, AD forms the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr <= 1'b0;
      who_eu <= 1'b0;
      off <= '0;
      wr_ack <= 1'b0;
      if_ack <= 1'b0;
      eu_ack <= 1'b0;
      if_addr <= '0;
      eu_addr <= '0;
      seg_we <= 1'b0;
      seg_sel <= 2'd0;
      seg_data <= '0;
      busy <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      if_ack <= 1'b0;
      eu_ack <= 1'b0;
      case (state)
        IDLE:
          if (wr_v) begin
            state <= WR;
            busy <= 1'b1;
            seg_we <= 1'b1;
            seg_sel <= wr_sel;
            seg_data <= wr_data;
          end else if (if_v || eu_v) begin
            state <= RD;
            busy <= 1'b1;
            who_eu <= pick_eu;
            rr <= !pick_eu;
            seg_sel <= pick_eu ? eu_sel : 2'd0;
            off <= pick_eu ? eu_offset : if_offset;
          end
        WR: begin
          state <= IDLE;
          busy <= 1'b0;
          seg_we <= 1'b0;
          seg_data <= '0;
          wr_ack <= 1'b1;
        end
        RD: state <= AD;
        AD: begin
          state <= IDLE;
          busy <= 1'b0;
          if (who_eu) begin
            eu_addr <= sum;
            eu_ack <= 1'b1;
          end else begin
            if_addr <= sum;
            if_ack <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
